// File: rtl/ext_ctrl_fsm.sv
// ext_ctrl_fsm: extension control FSM for the multi-cycle MIPS core.
// The main controller parks itself and pulses i_start. This block then runs
// the datapath for JAL, JR, JALR, BNE and LUI. It hands control back with a
// one-cycle o_done, and raises o_illegal with o_done for an unsupported op/funct.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             hand-off request, sampled only in IDLE
//   i_op, i_funct       instruction fields, latched with i_start
//   i_zero              live ALU zero flag (BNE Mealy term into PCWrite)
//   PCWriteCond..RegDst full datapath control bundle
//   ALUOp               ALU control (001 subtract, 110 LUI)
//   c_state             STATE_BASE + state offset
//   o_busy/o_done       non-IDLE indicator / hand-back strobe
//   o_illegal           unsupported instruction flag, with o_done
module ext_ctrl_fsm #(
  parameter logic [7:0] STATE_BASE = 8'd100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] IorD,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [2:0] ALUOp,
  output logic [7:0] c_state,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_illegal
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StJal     = 3'd1,
    StJr      = 3'd2,
    StJalr    = 3'd3,
    StBne     = 3'd4,
    StLuiEx   = 3'd5,
    StLuiWb   = 3'd6,
    StIllegal = 3'd7
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
    logic       bne;      // PCWrite is then gated live by ~i_zero
    logic       busy;
    logic       done;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] FnJr    = 6'b001000;
  localparam logic [5:0] FnJalr  = 6'b001001;

  function automatic state_e decode(input logic [5:0] op, input logic [5:0] funct);
    state_e s;
    s = StIllegal;
    if (op == OpJal) begin
      s = StJal;
    end else if (op == OpBne) begin
      s = StBne;
    end else if (op == OpLui) begin
      s = StLuiEx;
    end else if (op == OpRtype && funct == FnJr) begin
      s = StJr;
    end else if (op == OpRtype && funct == FnJalr) begin
      s = StJalr;
    end
    return s;
  endfunction

  function automatic ctrl_t ctrl_for(input state_e s);
    ctrl_t c;
    c = '0;
    c.busy = (s != StIdle);
    case (s)
      StJal: begin
        c.reg_dst    = 2'd2;
        c.mem_to_reg = 2'd2;
        c.reg_write  = 1'b1;
        c.pc_source  = 2'd2;
        c.pc_write   = 1'b1;
        c.done       = 1'b1;
      end
      StJr: begin
        c.pc_source = 2'd3;
        c.pc_write  = 1'b1;
        c.done      = 1'b1;
      end
      StJalr: begin
        c.reg_dst    = 2'd1;
        c.mem_to_reg = 2'd2;
        c.reg_write  = 1'b1;
        c.pc_source  = 2'd3;
        c.pc_write   = 1'b1;
        c.done       = 1'b1;
      end
      StBne: begin
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd0;
        c.alu_op    = 3'b001;
        c.pc_source = 2'd1;
        c.bne       = 1'b1;
        c.done      = 1'b1;
      end
      StLuiEx: begin
        c.alu_src_b = 2'd2;
        c.alu_op    = 3'b110;
      end
      StLuiWb: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      StIllegal: begin
        c.done    = 1'b1;
        c.illegal = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [5:0] op_q, funct_q;
  ctrl_t      ctrl_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_start) state_d = decode(i_op, i_funct);
      // The latched copy decides the write-back, so late op churn cannot leak in.
      StLuiEx: state_d = (decode(op_q, funct_q) == StLuiEx) ? StLuiWb : StIllegal;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      funct_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
      if (state_q == StIdle && i_start) begin
        op_q    <= i_op;
        funct_q <= i_funct;
      end
    end
  end

  assign PCWriteCond = 1'b0;
  assign MemRead     = 1'b0;
  assign MemWrite    = 1'b0;
  assign IRWrite     = 1'b0;
  assign IorD        = 2'd0;
  assign PCWrite     = ctrl_q.pc_write | (ctrl_q.bne & ~i_zero);
  assign RegWrite    = ctrl_q.reg_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign RegDst      = ctrl_q.reg_dst;
  assign ALUOp       = ctrl_q.alu_op;
  assign o_busy      = ctrl_q.busy;
  assign o_done      = ctrl_q.done;
  assign o_illegal   = ctrl_q.illegal;
  assign c_state     = STATE_BASE + {5'd0, state_q};

endmodule

// File: tb/tb_ext_ctrl_fsm.sv
// Self-checking bench for ext_ctrl_fsm. The reference model keeps a queue of
// the cycles still to run for the current instruction (as c_state offsets) and
// maps each offset to the outputs listed in the state table.
module tb_ext_ctrl_fsm;

  logic       clk, rst_n, start, zero;
  logic [5:0] op, funct;
  logic       pcwc, pcw, mr, mw, irw, rw;
  logic [1:0] iord, m2r, pcs, srca, srcb, rdst;
  logic [2:0] aluop;
  logic [7:0] cs;
  logic       busy, done, ill;

  ext_ctrl_fsm #(.STATE_BASE(8'd100)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_funct(funct),
    .i_zero(zero), .PCWriteCond(pcwc), .PCWrite(pcw), .MemRead(mr), .MemWrite(mw),
    .IRWrite(irw), .RegWrite(rw), .IorD(iord), .MemtoReg(m2r), .PCSource(pcs),
    .ALUSrcA(srca), .ALUSrcB(srcb), .RegDst(rdst), .ALUOp(aluop), .c_state(cs),
    .o_busy(busy), .o_done(done), .o_illegal(ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwc, pcw, mr, mw, irw, rw;
    logic [1:0] iord, m2r, pcs, srca, srcb, rdst;
    logic [2:0] aluop;
    logic [7:0] cs;
    logic       busy, done, ill;
  } obs_t;

  int   n_checks = 0;
  int   n_err    = 0;
  int   pending[$];
  obs_t act, exp;

  function automatic obs_t dut_obs();
    return '{pcwc, pcw, mr, mw, irw, rw, iord, m2r, pcs, srca, srcb, rdst, aluop, cs,
             busy, done, ill};
  endfunction

  // Expected outputs for the cycle currently shown, from the state table.
  function automatic obs_t model_obs(input logic z);
    obs_t o;
    int   t;
    o = '0;
    t = (pending.size() == 0) ? 0 : pending[0];
    o.cs   = 8'd100 + 8'(t);
    o.busy = (t != 0);
    case (t)
      1: begin o.rdst = 2; o.m2r = 2; o.rw = 1; o.pcs = 2; o.pcw = 1; o.done = 1; end
      2: begin o.pcs = 3; o.pcw = 1; o.done = 1; end
      3: begin o.rdst = 1; o.m2r = 2; o.rw = 1; o.pcs = 3; o.pcw = 1; o.done = 1; end
      4: begin o.srca = 1; o.aluop = 3'b001; o.pcs = 1; o.pcw = ~z; o.done = 1; end
      5: begin o.srcb = 2; o.aluop = 3'b110; end
      6: begin o.rw = 1; o.done = 1; end
      7: begin o.done = 1; o.ill = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic model_accept(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000011) pending.push_back(1);
    else if (o == 6'b000101) pending.push_back(4);
    else if (o == 6'b001111) begin pending.push_back(5); pending.push_back(6); end
    else if (o == 6'b000000 && f == 6'b001000) pending.push_back(2);
    else if (o == 6'b000000 && f == 6'b001001) pending.push_back(3);
    else pending.push_back(7);
  endtask

  // One clock: advance the model on the edge, drive the next inputs, then stop at negedge.
  task automatic tick(input logic s, input logic [5:0] o, input logic [5:0] f,
                      input logic z);
    @(posedge clk);
    if (!rst_n) pending.delete();
    else if (pending.size() != 0) void'(pending.pop_front());
    else if (start) model_accept(op, funct);
    #1;
    start = s; op = o; funct = f; zero = z;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; op = 0; funct = 0; zero = 0;
    #3;
    exp = model_obs(zero); act = dut_obs(); n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL reset_init act=%h exp=%h", act, exp); end
    @(negedge clk); #2 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 6'h00, 6'h00, 0);
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL idle_after_reset act=%h exp=%h", act, exp); end
    end
    tick(1, 6'b001111, 6'h00, 0);
    tick(0, 6'h00, 6'h00, 0);
    exp = model_obs(zero); act = dut_obs(); n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL lui_ex_before_reset act=%h exp=%h", act, exp); end
    #2 rst_n = 0;
    pending.delete();
    #1;
    exp = model_obs(zero); act = dut_obs(); n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL reset_mid_lui act=%h exp=%h", act, exp); end
    tick(0, 6'h00, 6'h00, 0);
    exp = model_obs(zero); act = dut_obs(); n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL reset_held act=%h exp=%h", act, exp); end
    #2 rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      tick(0, 6'h00, 6'h00, 0);
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL idle_after_release act=%h exp=%h", act, exp); end
    end
  endtask

  task automatic test_jal();
    tick(1, 6'b000011, 6'h00, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 6'h00, 6'h00, 0);
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL jal_cyc%0d act=%h exp=%h", i, act, exp); end
    end
  endtask

  task automatic test_jr_jalr();
    logic [5:0] fn[2];
    fn[0] = 6'b001000; fn[1] = 6'b001001;
    for (int k = 0; k < 2; k++) begin
      tick(1, 6'b000000, fn[k], 0);
      for (int i = 0; i < 2; i++) begin
        tick(0, 6'h00, 6'h00, 1);
        exp = model_obs(zero); act = dut_obs(); n_checks++;
        if (act !== exp) begin
          n_err++; $display("FAIL jr_jalr_%0d_cyc%0d act=%h exp=%h", k, i, act, exp);
        end
      end
    end
  endtask

  task automatic test_bne();
    for (int k = 0; k < 2; k++) begin
      tick(1, 6'b000101, 6'h00, 0);
      tick(0, 6'h00, 6'h00, (k == 0) ? 1'b1 : 1'b0);
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL bne_zero%0d act=%h exp=%h", zero, act, exp); end
      // Flip zero inside the same cycle: PCWrite must follow it combinationally.
      zero = ~zero; #1;
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL bne_live_zero act=%h exp=%h", act, exp); end
      tick(0, 6'h00, 6'h00, 0);
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL bne_return act=%h exp=%h", act, exp); end
    end
  endtask

  task automatic test_lui_churn();
    tick(1, 6'b001111, 6'h00, 0);
    // Start stays high and op churns to JAL; the next sequence must wait for IDLE.
    for (int i = 0; i < 6; i++) begin
      tick(1, 6'b000011, 6'h00, 0);
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL lui_churn_cyc%0d act=%h exp=%h", i, act, exp); end
    end
    tick(0, 6'h00, 6'h00, 0);
    tick(0, 6'h00, 6'h00, 0);
  endtask

  task automatic test_illegal();
    tick(1, 6'b100011, 6'h00, 0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 6'h00, 6'h00, 0);
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL illegal_cyc%0d act=%h exp=%h", i, act, exp); end
    end
    tick(1, 6'b000000, 6'b100000, 0);
    tick(0, 6'h00, 6'h00, 0);
    exp = model_obs(zero); act = dut_obs(); n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL illegal_funct act=%h exp=%h", act, exp); end
  endtask

  task automatic test_random_back_to_back();
    logic [5:0] o, f;
    logic       s;
    for (int i = 0; i < 400; i++) begin
      f = 6'($urandom);
      case ($urandom_range(0, 6))
        0: o = 6'b000011;
        1: begin o = 6'b000000; f = 6'b001000; end
        2: begin o = 6'b000000; f = 6'b001001; end
        3: o = 6'b000101;
        4: o = 6'b001111;
        5: o = 6'b000000;
        default: o = 6'($urandom);
      endcase
      s = (i < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick(s, o, f, 1'($urandom));
      exp = model_obs(zero); act = dut_obs(); n_checks++;
      if (act !== exp) begin n_err++; $display("FAIL random_cyc%0d act=%h exp=%h", i, act, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_jr_jalr();
    test_bne();
    test_lui_churn();
    test_illegal();
    test_random_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ext_ctrl_fsm.md
# ext_ctrl_fsm

Extension control FSM for the multi-cycle MIPS core. It is the responder side of the main-FSM hand-off: when the main controller parks itself, it pulses `i_start`. This block then drives the full datapath control bundle for the extended instructions JAL, JR, JALR, BNE and LUI. It returns control with a one-cycle `o_done`, after which the main controller resumes at instruction fetch.

## Interface
- `STATE_BASE`, default 8'd100: `c_state` code of IDLE; the other states are STATE_BASE+1 … +7.
- `i_clk` in 1: the single clock; all state updates on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: hand-off request; sampled only in IDLE.
- `i_op` in 6: opcode, sampled with `i_start`.
- `i_funct` in 6: funct field, sampled with `i_start`.
- `i_zero` in 1: ALU zero flag (live).
- `PCWriteCond`, `PCWrite`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite` out 1: datapath enables.
- `IorD`, `MemtoReg`, `PCSource`, `ALUSrcA`, `ALUSrcB`, `RegDst` out 2: datapath mux selects.
- `ALUOp` out 3: ALU control.
- `c_state` out 8: current state code.
- `o_busy` out 1: high in every non-IDLE state.
- `o_done` out 1: hand-back; high for exactly one cycle, in the final state of each sequence.
- `o_illegal` out 1: high together with `o_done` when the op/funct pair is unsupported.

## Operation
- Encodings:
  - MemtoReg: 0 = ALUOut, 2 = PC.
  - PCSource: 1 = ALUOut (branch target), 2 = jump target, 3 = register A.
  - ALUSrcA: 1 = A.
  - ALUSrcB: 0 = B, 2 = sign-extended immediate.
  - RegDst: 0 = rt, 1 = rd, 2 = $31.
  - ALUOp: 001 = subtract, 110 = LUI.
- Every output not listed for a state is 0 in that state. IorD, MemRead, MemWrite, IRWrite and PCWriteCond are always 0.
- States and their non-zero outputs:
  - IDLE (+0): none.
  - JAL (+1): RegDst=2, MemtoReg=2, RegWrite=1, PCSource=2, PCWrite=1, o_done=1.
  - JR (+2): PCSource=3, PCWrite=1, o_done=1.
  - JALR (+3): RegDst=1, MemtoReg=2, RegWrite=1, PCSource=3, PCWrite=1, o_done=1.
  - BNE (+4): ALUSrcA=1, ALUSrcB=0, ALUOp=001, PCSource=1, PCWrite=~i_zero (Mealy term), o_done=1.
  - LUI_EX (+5): ALUSrcB=2, ALUOp=110.
  - LUI_WB (+6): RegDst=0, MemtoReg=0, RegWrite=1, o_done=1.
  - ILLEGAL (+7): o_done=1, o_illegal=1.
- Decode in IDLE when `i_start`=1 (op/funct also latched into internal registers):
  - op 000011 → JAL.
  - op 000000, funct 001000 → JR.
  - op 000000, funct 001001 → JALR.
  - op 000101 → BNE.
  - op 001111 → LUI_EX.
  - Anything else → ILLEGAL.
- Transitions:
  - LUI_EX → LUI_WB.
  - Every state with o_done=1 → IDLE.
  - IDLE with `i_start`=0 → IDLE.

## Timing
- Reset (asynchronous, immediate, mid-sequence included): state=IDLE, latched op/funct=0. All control outputs, `o_busy`, `o_done` and `o_illegal` are 0; `c_state`=STATE_BASE. No partial write can complete once reset is asserted.
- Start → first active state: 1 clock edge.
- Active length:
  - JAL, JR, JALR, BNE, ILLEGAL: 1 cycle.
  - LUI: 2 cycles.
- `o_done` cycle → IDLE on the next edge. Earliest accepted restart is the cycle after `o_done`.
- `i_start` in any non-IDLE state, including the `o_done` cycle, is ignored and not queued.
- `i_op`/`i_funct` changes after the start cycle have no effect; decode uses the latched copy, which holds through LUI_WB.
- BNE: `i_zero` is combinational into PCWrite within the BNE cycle. The datapath guarantees `i_zero` is stable before the edge.
- Back-to-back starts (start asserted continuously) give one sequence per (length+1) cycles.

## Test plan
- Reset: assert `i_rst_n`=0 during LUI_EX → outputs immediately 0, `c_state`=100. After release with `i_start`=0 → stays IDLE, `o_busy`=0.
- JAL: `i_start`=1, op=000011 → next cycle `c_state`=101, RegDst=2, MemtoReg=2, RegWrite=1, PCSource=2, PCWrite=1, `o_done`=1. Following cycle `c_state`=100.
- JR/JALR: op=0 with funct=001000, then funct=001001 → `c_state` 102 (PCSource=3, PCWrite=1, RegWrite=0), then 103 (RegWrite=1, RegDst=1, PCWrite=1).
- BNE: op=000101 with `i_zero`=1 → PCWrite=0. With `i_zero`=0 → PCWrite=1, PCSource=1, ALUOp=001. `o_done`=1 in both cases.
- LUI with input churn: op=001111, then `i_op` changed to 000011 during LUI_EX → `c_state` 105 then 106. RegWrite=1 only in 106; `o_done` only in 106. `i_start` held high through 106 → no new sequence until `c_state`=100.
- Illegal: op=100011 → `c_state`=107, `o_done`=1, `o_illegal`=1, all controls 0. IDLE on the next cycle.
